alu: RTL and testbench

- 8-bit registered ALU for the simple processor datapath. It takes two unsigned operands and a one-hot operation select from the instruction decoder.
- It produces an 8-bit result split into two 4-bit nibbles, which drive the left and right seven-segment display digits, plus a negative flag for subtraction.
- Result and flag are registered on the rising clock edge.

---
 rtl/alu_if.sv | 27 ++
 rtl/alu.sv | 59 +++++
 tb/tb_alu.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/select inputs and registered result outputs of the ALU
interface alu_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] selector;
    logic        negative;
    logic [3:0]  left;
    logic [3:0]  right;

    modport master (
        output a,
        output b,
        output selector,
        input  negative,
        input  left,
        input  right
    );

    modport slave (
        input  a,
        input  b,
        input  selector,
        output negative,
        output left,
        output right
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit registered ALU, one-hot op select, result split into display nibbles
module alu (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);
    logic [7:0] result_q;
    logic       negative_q;
    logic [7:0] result_d;
    logic       negative_d;
    logic       sel_unused;

    // Bits 9..15 are reserved for the decoder and never change the result.
    assign sel_unused = ^bus.selector[15:9];

    // Lowest set bit wins, so a multi-hot selector still yields one defined op.
    always_comb begin
        result_d   = 8'h00;
        negative_d = 1'b0;
        if (bus.selector[0]) begin
            result_d = bus.a + bus.b;
        end else if (bus.selector[1]) begin
            if (bus.a >= bus.b) begin
                result_d = bus.a - bus.b;
            end else begin
                result_d   = bus.b - bus.a;
                negative_d = 1'b1;
            end
        end else if (bus.selector[2]) begin
            result_d = ~bus.a;
        end else if (bus.selector[3]) begin
            result_d = ~(bus.a & bus.b);
        end else if (bus.selector[4]) begin
            result_d = ~(bus.a | bus.b);
        end else if (bus.selector[5]) begin
            result_d = bus.a & bus.b;
        end else if (bus.selector[6]) begin
            result_d = bus.a ^ bus.b;
        end else if (bus.selector[7]) begin
            result_d = bus.a | bus.b;
        end else if (bus.selector[8]) begin
            result_d = ~(bus.a ^ bus.b);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= 8'h00;
            negative_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            negative_q <= negative_d;
        end
    end

    assign bus.left     = result_q[7:4];
    assign bus.right    = result_q[3:0];
    assign bus.negative = negative_q;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed scoreboard bench for alu
module tb_alu;
    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    typedef struct {
        logic [8:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [15:0] sel, input logic en, input logic [7:0] er,
                         input string tag);
        exp_t e;
        reset        = r;
        bus.a        = ta;
        bus.b        = tb_;
        bus.selector = sel;
        e.exp = {en, er};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check(e.tag, {bus.negative, bus.left, bus.right}, e.exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset        = 1'b1;
        bus.a        = 8'hA5;
        bus.b        = 8'h3C;
        bus.selector = 16'h0002;

        // Reset and hold
        @(negedge clk);
        drive(1'b1, 8'hA5, 8'h3C, 16'h0002, 1'b0, 8'h00, "reset_edge1"); tick_check();
        drive(1'b1, 8'h01, 8'hFF, 16'h0001, 1'b0, 8'h00, "reset_edge2"); tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0000, 1'b0, 8'h00, "release_sel0"); tick_check();

        // Full operation sweep
        drive(1'b0, 8'h59, 8'h72, 16'h0001, 1'b0, 8'hCB, "sweep_add");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0002, 1'b1, 8'h19, "sweep_sub");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0004, 1'b0, 8'hA6, "sweep_not");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0008, 1'b0, 8'hAF, "sweep_nand"); tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0010, 1'b0, 8'h84, "sweep_nor");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0020, 1'b0, 8'h50, "sweep_and");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0040, 1'b0, 8'h2B, "sweep_xor");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0080, 1'b0, 8'h7B, "sweep_or");   tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0100, 1'b0, 8'hD4, "sweep_xnor"); tick_check();

        // Arithmetic boundaries
        drive(1'b0, 8'hFF, 8'h01, 16'h0001, 1'b0, 8'h00, "add_wrap");     tick_check();
        drive(1'b0, 8'h72, 8'h59, 16'h0002, 1'b0, 8'h19, "sub_pos");      tick_check();
        drive(1'b0, 8'h40, 8'h40, 16'h0002, 1'b0, 8'h00, "sub_equal");    tick_check();
        drive(1'b0, 8'h00, 8'hFF, 16'h0002, 1'b1, 8'hFF, "sub_neg_max");  tick_check();

        // Select edge cases
        drive(1'b0, 8'h59, 8'h72, 16'h0003, 1'b0, 8'hCB, "multi_hot_add"); tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h8000, 1'b0, 8'h00, "reserved_only"); tick_check();
        drive(1'b0, 8'h12, 8'h34, 16'h0180, 1'b0, 8'h36, "multi_hot_or");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0000, 1'b0, 8'h00, "sel_zero");      tick_check();

        // Latency: outputs must not move until the next rising edge
        drive(1'b0, 8'h59, 8'h72, 16'h0001, 1'b0, 8'hCB, "lat_add"); tick_check();
        #2;
        bus.selector = 16'h0002;
        #1;
        check("lat_hold_mid", {bus.negative, bus.left, bus.right}, 9'h0CB);
        drive(1'b0, 8'h59, 8'h72, 16'h0002, 1'b1, 8'h19, "lat_sub"); tick_check();

        // Reset priority over a negative subtraction, then resume
        drive(1'b1, 8'h59, 8'h72, 16'h0002, 1'b0, 8'h00, "reset_prio");  tick_check();
        drive(1'b0, 8'h59, 8'h72, 16'h0040, 1'b0, 8'h2B, "resume_xor");  tick_check();

        check("sb_drained", {8'h00, sb.size() == 0}, 9'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
